// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the CPU data-memory path: RV32I load/store funct3
// values, load-store unit state encoding, watchdog default and the
// load-data extension helper.
package riscv_mem_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 16;

    // Load funct3 encodings (stores reuse 000/001/010)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    // Sign/zero extension of lane-0 aligned load data
    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_B:    return {{24{d[7]}}, d[7:0]};
            F3_BU:   return {24'd0, d[7:0]};
            F3_H:    return {{16{d[15]}}, d[15:0]};
            F3_HU:   return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align_check.sv
// Combinational legality check for one memory op.
// Ports: is_load, funct3, addr_lo (byte address [1:0]) in;
//        illegal (unsupported funct3), misaligned (bad alignment) out.
// illegal takes priority: misaligned is never raised together with illegal.
module lsu_align_check
    import riscv_mem_pkg::*;
(
    input  logic       is_load,
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lo,
    output logic       illegal,
    output logic       misaligned
);

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (funct3)
            F3_B:    misaligned = 1'b0;
            F3_H:    misaligned = addr_lo[0];
            F3_W:    misaligned = |addr_lo;
            F3_BU:   illegal    = ~is_load;
            F3_HU: begin
                illegal    = ~is_load;
                misaligned = addr_lo[0];
            end
            default: illegal    = 1'b1;
        endcase
        if (illegal) begin
            misaligned = 1'b0;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Initiator side of the CPU data-memory port. Accepts one load/store from
// the MEM stage, checks legality, issues it to data_memory, waits out
// mem_busy (with a watchdog) and returns extended load data.
// Ports: clk, reset (sync, active-high), flush;
//        req_* request from MEM stage;
//        stall, resp_valid/resp_data/resp_rd, misaligned, illegal, bus_err to pipeline;
//        mem_read_en/mem_write_en/mem_addr/mem_wdata/mem_load_type/mem_store_type
//        to data_memory, mem_rdata/mem_busy from data_memory.
module load_store_unit
    import riscv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_valid,
    input  logic              req_is_load,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic [4:0]        resp_rd,
    output logic              misaligned,
    output logic              illegal,
    output logic              bus_err,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        mem_load_type,
    output logic [2:0]        mem_store_type,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_busy
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    lsu_state_t       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             is_load_q;
    logic [4:0]       rd_q;
    logic [31:0]      data_q;
    logic [4:0]       resp_rd_q;
    logic             chk_illegal;
    logic             chk_misaligned;
    logic             wait_done;
    logic             wait_expired;

    lsu_align_check u_align (
        .is_load    (req_is_load),
        .funct3     (req_funct3),
        .addr_lo    (req_addr[1:0]),
        .illegal    (chk_illegal),
        .misaligned (chk_misaligned)
    );

    // WAIT exit conditions; a completed access wins over the watchdog
    assign wait_done    = (state == ST_WAIT) && (wait_cnt != '0) && !mem_busy;
    assign wait_expired = (state == ST_WAIT) && !wait_done &&
                          (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // State-decoded outputs; flush can still kill the enable/response in its own cycle
    assign stall        = (state != ST_IDLE);
    assign mem_read_en  = (state == ST_ISSUE) && is_load_q && !flush;
    assign mem_write_en = (state == ST_ISSUE) && !is_load_q && !flush;
    assign bus_err      = wait_expired && !flush;
    assign resp_valid   = (state == ST_RESP) && !flush;
    assign resp_data    = resp_valid ? data_q : 32'd0;
    assign resp_rd      = resp_valid ? resp_rd_q : 5'd0;

    // FSM, request latch, watchdog counter and response capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            wait_cnt       <= '0;
            is_load_q      <= 1'b0;
            rd_q           <= '0;
            data_q         <= '0;
            resp_rd_q      <= '0;
            illegal        <= 1'b0;
            misaligned     <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_load_type  <= '0;
            mem_store_type <= '0;
        end else begin
            illegal    <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && !flush) begin
                        if (chk_illegal) begin
                            illegal <= 1'b1;
                        end else if (chk_misaligned) begin
                            misaligned <= 1'b1;
                        end else begin
                            mem_addr       <= ADDR_W'(req_addr);
                            mem_wdata      <= req_wdata;
                            mem_load_type  <= req_funct3;
                            mem_store_type <= req_funct3;
                            is_load_q      <= req_is_load;
                            rd_q           <= req_rd;
                            state          <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= flush ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (flush || wait_expired) begin
                        state <= ST_IDLE;
                    end else if (wait_done) begin
                        data_q    <= is_load_q ? extend_load(mem_load_type, mem_rdata) : 32'd0;
                        resp_rd_q <= is_load_q ? rd_q : 5'd0;
                        state     <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
